// File: rtl/ws_feeder_4x4.sv
// Weight-stationary feeder: loads N weight rows into the array, then skews activation vectors.
// Optional macro WS_FEEDER_WT_REUSE_EN adds keep_wt to skip the weight load on start.
module ws_feeder_4x4 #(
    parameter int unsigned bit_width = 8,
    parameter int unsigned N         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef WS_FEEDER_WT_REUSE_EN
    input  logic                   keep_wt,
`endif
    input  logic                   wt_valid,
    output logic                   wt_ready,
    input  logic [N*bit_width-1:0] wt_row,
    input  logic                   act_valid,
    output logic                   act_ready,
    input  logic [N*bit_width-1:0] act_vec,
    input  logic                   act_last,
    output logic [N-1:0]           ctrl_row,
    output logic [N*bit_width-1:0] wt_col,
    output logic [N*bit_width-1:0] data_skew,
    output logic [N-1:0]           lane_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CntW = (2 * N > 2) ? $clog2(2 * N) : 1;
    localparam logic [CntW-1:0] LastRow   = CntW'(N - 1);
    localparam logic [CntW-1:0] LastDrain = CntW'(2 * N - 2);

    typedef enum logic [1:0] {StIdle, StLoadWt, StStream, StDrain} state_t;

    state_t                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [N-1:0]           ctrl_row_q, ctrl_row_d;
    logic [N*bit_width-1:0] wt_col_q, wt_col_d;
    logic                   keep;
    logic                   push_valid;
    logic [N*bit_width-1:0] push_data;

`ifdef WS_FEEDER_WT_REUSE_EN
    assign keep = keep_wt;
`else
    assign keep = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ctrl_row_d = '0;
        wt_col_d   = wt_col_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = keep ? StStream : StLoadWt;
                    cnt_d   = '0;
                end
            end
            StLoadWt: begin
                if (wt_valid) begin
                    ctrl_row_d = N'(1) << cnt_q;
                    wt_col_d   = wt_row;
                    if (cnt_q == LastRow) begin
                        state_d = StStream;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (act_valid && act_last) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                if (cnt_q == LastDrain) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ctrl_row_q <= '0;
            wt_col_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ctrl_row_q <= ctrl_row_d;
            wt_col_q   <= wt_col_d;
        end
    end

    assign wt_ready  = (state_q == StLoadWt);
    assign act_ready = (state_q == StStream);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDrain) && (cnt_q == LastDrain);
    assign ctrl_row  = ctrl_row_q;
    assign wt_col    = wt_col_q;

    // Every cycle pushes into the skew; non-STREAM cycles and bubbles push zeros.
    assign push_valid = (state_q == StStream) && act_valid;
    assign push_data  = push_valid ? act_vec : '0;

    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [bit_width-1:0] pipe_q [r+1];
        logic                 vld_q  [r+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) begin
                    pipe_q[i] <= '0;
                    vld_q[i]  <= 1'b0;
                end
            end else begin
                pipe_q[0] <= push_data[r*bit_width +: bit_width];
                vld_q[0]  <= push_valid;
                for (int i = 1; i <= r; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                end
            end
        end

        assign data_skew[r*bit_width +: bit_width] = pipe_q[r];
        assign lane_valid[r]                       = vld_q[r];
    end

endmodule

// File: doc/ws_feeder_4x4.md
WS_FEEDER_4X4 -- requirements
Module: ws_feeder_4x4

Interface
REQ-001 The block SHALL have parameter bit_width, default 8, giving the weight and activation element width.
REQ-002 The block SHALL have parameter N, default 4, giving the array dimension (rows = columns = N).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a tile.
REQ-006 The block SHALL have port wt_valid  input  1  weight row beat offered.
REQ-007 The block SHALL have port wt_ready  output  1  weight row beat accepted when high with wt_valid.
REQ-008 The block SHALL have port wt_row  input  N*bit_width  one array row of weights; slice c is for column c.
REQ-009 The block SHALL have port act_valid  input  1  activation vector offered.
REQ-010 The block SHALL have port act_ready  output  1  activation vector accepted when high with act_valid.
REQ-011 The block SHALL have port act_vec  input  N*bit_width  activation vector; slice r is for array row r.
REQ-012 The block SHALL have port act_last  input  1  marks the final vector of the tile; qualified by act_valid.
REQ-013 The block SHALL have port ctrl_row  output  N  per-row PE weight-load control; bit r drives the control input of array row r.
REQ-014 The block SHALL have port wt_col  output  N*bit_width  weight bus shared by all rows; slice c drives the wt_path_in input of column c.
REQ-015 The block SHALL have port data_skew  output  N*bit_width  skewed activations; slice r drives the data_in input of row r, column 0.
REQ-016 The block SHALL have port lane_valid  output  N  bit r high when slice r of data_skew carries a real activation.
REQ-017 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-018 The block SHALL have port done  output  1  single-cycle tile-complete pulse.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, LOAD_WT, STREAM and DRAIN.
REQ-020 In IDLE, start SHALL move the FSM to LOAD_WT with row counter 0; start in any other state SHALL be ignored.
REQ-021 wt_ready SHALL be high only in LOAD_WT, and act_ready SHALL be high only in STREAM.
REQ-022 A weight beat accepted in cycle t with row counter k SHALL produce ctrl_row = one-hot(k) and wt_col = wt_row in cycle t+1; in all other cycles ctrl_row SHALL be 0.
REQ-023 Weight rows SHALL load in order 0 to N-1; the beat that loads row N-1 SHALL move the FSM to STREAM.
REQ-024 In STREAM, an accepted vector SHALL enter the skew; slice r SHALL appear on data_skew r+1 cycles after acceptance, with lane_valid[r] high in that cycle.
REQ-025 A STREAM cycle with act_valid low SHALL insert a bubble: value 0 with lane_valid 0, skewed identically to a real vector.
REQ-026 An accepted vector with act_last=1 SHALL move the FSM to DRAIN.
REQ-027 DRAIN SHALL last exactly 2N-1 cycles and push only zeros into the skew; done SHALL be high in the last DRAIN cycle, after which the FSM SHALL return to IDLE.
REQ-028 data_skew and lane_valid SHALL be 0 outside skewed real data, and wt_col SHALL hold its last value when ctrl_row is 0.
REQ-029 ctrl_row and lane_valid SHALL never be nonzero in the same cycle.

Reset
REQ-030 rst SHALL force, asynchronously: FSM to IDLE, counters to 0, skew registers to 0, and all outputs to 0.
REQ-031 rst asserted mid-tile SHALL abandon the tile; the next tile SHALL require a new start and a full weight load.

Configuration
REQ-032 When macro WS_FEEDER_WT_REUSE_EN is defined, the block SHALL add input keep_wt (1 bit), and start with keep_wt=1 SHALL go directly from IDLE to STREAM, retaining the array weights.
REQ-033 When WS_FEEDER_WT_REUSE_EN is undefined, keep_wt SHALL be absent and every start SHALL enter LOAD_WT.

Verification
REQ-034 The bench SHALL cover: reset during STREAM -> all outputs 0 immediately, busy 0; a later start enters LOAD_WT.
REQ-035 The bench SHALL cover: start, then 4 back-to-back wt_row beats 0x04030201..0x10 0F0E0D -> ctrl_row 0001, 0010, 0100, 1000 on consecutive cycles with the matching wt_col; a one-cycle wt_valid gap gives ctrl_row 0 for that cycle.
REQ-036 The bench SHALL cover: act_vec {4,3,2,1} accepted at cycle t with act_last=1 -> lane r = r+1 at cycle t+1+r, lane_valid likewise; done at cycle t+7; IDLE at t+8.
REQ-037 The bench SHALL cover: vectors A, bubble, B -> each lane shows A, 0 (lane_valid 0), B in successive cycles, offset by lane index.
REQ-038 The bench SHALL cover: a start pulse during STREAM -> no effect on state or outputs.
REQ-039 The bench SHALL cover, with WS_FEEDER_WT_REUSE_EN defined: start with keep_wt=1 -> act_ready high in the next cycle, ctrl_row stays 0 for the whole tile.
